// File: rtl/radar_capture_pkg.sv
// rtl/radar_capture_pkg.sv - shared types, header field layout and sample packing for radar_adc_capture
package radar_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_READY   = 3'd2,
    ST_STREAM  = 3'd3,
    ST_FLUSH   = 3'd4
  } state_e;

  localparam int HDR_CNT_W    = 16;
  localparam int HDR_OVF_W    = 1;
  localparam int HDR_LEN_W    = 15;
  localparam int SAMPLE_W_MAX = 32;

  // {Q,I} with I in the low half; callers cast the result to 2*SAMPLE_W
  function automatic logic [2*SAMPLE_W_MAX-1:0] pack_qi(
    input logic [SAMPLE_W_MAX-1:0] i,
    input logic [SAMPLE_W_MAX-1:0] q,
    input int                      w
  );
    pack_qi = ({{SAMPLE_W_MAX{1'b0}}, q} << w) | {{SAMPLE_W_MAX{1'b0}}, i};
  endfunction

endpackage

// File: rtl/radar_sample_ram.sv
// rtl/radar_sample_ram.sv - simple dual-port sample buffer, one write port, one registered read port
module radar_sample_ram #(
  parameter int   DEPTH  = 1024,
  parameter int   DATA_W = 32,
  localparam int  ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/radar_adc_capture.sv
// rtl/radar_adc_capture.sv - captures ADC I/Q frames and streams them out on AXI-Stream
// Optional frame header beat: define RADAR_CAPTURE_HEADER_EN
module radar_adc_capture #(
  parameter int  DEPTH    = 1024,
  parameter int  SAMPLE_W = 16,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  adc_enable,
  input  logic                  adc_valid,
  input  logic [SAMPLE_W-1:0]   adc_data_i,
  input  logic [SAMPLE_W-1:0]   adc_data_q,
  input  logic                  data_tx_init,
  output logic                  data_tx_ready,
  output logic                  data_tx_active,
  output logic                  data_tx_done,
  output logic [2*SAMPLE_W-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ADDR_W:0]       frame_len,
  output logic                  frame_overflow,
  output logic [31:0]           frame_count
);
  import radar_capture_pkg::*;

  localparam int DATA_W = 2 * SAMPLE_W;
  localparam int CNT_W  = ADDR_W + 2;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
`ifdef RADAR_CAPTURE_HEADER_EN
  localparam int HDR_BEATS = 1;
`else
  localparam int HDR_BEATS = 0;
`endif

  state_e            state_q, state_d;
  logic              en_q;
  logic [ADDR_W:0]   frame_len_q, frame_len_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       count_q, count_d;
  logic              ready_q, ready_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata, src_data;

  logic              pend_q, pend_last_q;
  logic              out_valid_q, out_last_q, skid_valid_q, skid_last_q;
  logic [DATA_W-1:0] out_data_q, skid_data_q;
  logic              pop, can_issue, issue, issue_last;
  logic [1:0]        occ;
  logic [CNT_W-1:0]  rd_idx, total_beats;

  assign ram_wdata = DATA_W'(pack_qi(SAMPLE_W_MAX'(adc_data_i), SAMPLE_W_MAX'(adc_data_q), SAMPLE_W));

  // Reads are issued only when the output register plus skid can absorb the result
  assign pop         = out_valid_q & m_axis_tready;
  assign occ         = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, pend_q};
  assign can_issue   = occ <= ({1'b0, pop} + 2'd1);
  assign total_beats = CNT_W'(frame_len_q) + CNT_W'(HDR_BEATS);
  assign rd_idx      = (state_q == ST_STREAM) ? rd_cnt_q : '0;
  assign issue       = ((state_q == ST_STREAM) && (rd_cnt_q < total_beats) && can_issue)
                     || ((state_q == ST_READY) && data_tx_init);
  assign issue_last  = (rd_idx == total_beats - CNT_W'(1));

  radar_sample_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_ram (
    .clk_i   (aclk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (issue),
    .raddr_i (ADDR_W'(rd_idx - CNT_W'(HDR_BEATS))),
    .rdata_o (ram_rdata)
  );

`ifdef RADAR_CAPTURE_HEADER_EN
  logic              pend_hdr_q;
  logic [DATA_W-1:0] hdr_word;
  assign hdr_word = DATA_W'({count_q[HDR_CNT_W-1:0], {HDR_OVF_W{1'b0}}, HDR_LEN_W'(frame_len_q)});
  assign src_data = pend_hdr_q ? hdr_word : ram_rdata;
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) pend_hdr_q <= 1'b0;
    else        pend_hdr_q <= issue && (rd_idx == '0);
  end
`else
  assign src_data = ram_rdata;
`endif

  always_comb begin
    state_d     = state_q;
    frame_len_d = frame_len_q;
    ovf_d       = ovf_q;
    count_d     = count_q;
    ready_d     = ready_q;
    ram_we      = 1'b0;
    ram_waddr   = frame_len_q[ADDR_W-1:0];
    rd_cnt_d    = (state_q == ST_STREAM) ? rd_cnt_q + CNT_W'(issue) : CNT_W'(issue);
    case (state_q)
      ST_IDLE: if (adc_enable && !en_q) begin
        state_d     = ST_CAPTURE;
        ovf_d       = 1'b0;
        ram_waddr   = '0;
        ram_we      = adc_valid;
        frame_len_d = (ADDR_W+1)'(adc_valid);
      end
      ST_CAPTURE: begin
        if (!adc_enable) begin
          state_d = (frame_len_q != '0) ? ST_READY : ST_IDLE;
          ready_d = (frame_len_q != '0);
        end else if (adc_valid) begin
          if (frame_len_q != DEPTH_L) begin
            ram_we      = 1'b1;
            frame_len_d = frame_len_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      ST_READY: if (data_tx_init) begin
        state_d = ST_STREAM;
        ready_d = 1'b0;
      end
      ST_STREAM: if (pop && out_last_q) state_d = ST_FLUSH;
      ST_FLUSH: begin
        state_d = ST_IDLE;
        count_d = count_q + 32'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      en_q        <= 1'b0;
      frame_len_q <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      ready_q     <= 1'b0;
      rd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= adc_enable;
      frame_len_q <= frame_len_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      rd_cnt_q    <= rd_cnt_d;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pend_q       <= 1'b0;
      pend_last_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      pend_q      <= issue;
      pend_last_q <= issue_last;
      if (!out_valid_q || pop) begin
        if (skid_valid_q) begin
          out_valid_q <= 1'b1;
          out_data_q  <= skid_data_q;
          out_last_q  <= skid_last_q;
        end else if (pend_q) begin
          out_valid_q <= 1'b1;
          out_data_q  <= src_data;
          out_last_q  <= pend_last_q;
        end else begin
          out_valid_q <= 1'b0;
        end
        skid_valid_q <= skid_valid_q && pend_q;
        if (skid_valid_q && pend_q) begin
          skid_data_q <= src_data;
          skid_last_q <= pend_last_q;
        end
      end else if (pend_q) begin
        skid_valid_q <= 1'b1;
        skid_data_q  <= src_data;
        skid_last_q  <= pend_last_q;
      end
    end
  end

  assign data_tx_ready  = ready_q;
  assign data_tx_active = (state_q == ST_STREAM);
  assign data_tx_done   = (state_q == ST_FLUSH);
  assign m_axis_tdata   = out_data_q;
  assign m_axis_tvalid  = out_valid_q;
  assign m_axis_tlast   = out_valid_q & out_last_q;
  assign frame_len      = frame_len_q;
  assign frame_overflow = ovf_q;
  assign frame_count    = count_q;

endmodule

// File: tb/tb_radar_adc_capture.sv
// tb/tb_radar_adc_capture.sv - directed self-checking bench for radar_adc_capture
module tb_radar_adc_capture;

`ifdef RADAR_CAPTURE_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        en_a = 1'b0, en_b = 1'b0, init_a = 1'b0, init_b = 1'b0;
  logic        adc_valid = 1'b0;
  logic        m_axis_tready = 1'b1;
  logic [15:0] adc_i = '0, adc_q = '0;

  logic        a_ready, a_active, a_done, a_tvalid, a_tlast, a_ovf;
  logic [31:0] a_tdata, a_count;
  logic [8:0]  a_len;
  logic        b_ready, b_active, b_done, b_tvalid, b_tlast, b_ovf;
  logic [31:0] b_tdata, b_count;
  logic [4:0]  b_len;

  int   total = 0;
  int   bad = 0;
  logic sel_b = 1'b0;

  logic        o_tvalid, o_tlast, o_done, o_active;
  logic [31:0] o_tdata;
  assign o_tvalid = sel_b ? b_tvalid : a_tvalid;
  assign o_tlast  = sel_b ? b_tlast  : a_tlast;
  assign o_done   = sel_b ? b_done   : a_done;
  assign o_active = sel_b ? b_active : a_active;
  assign o_tdata  = sel_b ? b_tdata  : a_tdata;

  always #5 aclk = ~aclk;

  radar_adc_capture #(.DEPTH(256), .SAMPLE_W(16)) dut_a (
    .aclk(aclk), .areset(areset), .adc_enable(en_a), .adc_valid(adc_valid),
    .adc_data_i(adc_i), .adc_data_q(adc_q), .data_tx_init(init_a),
    .data_tx_ready(a_ready), .data_tx_active(a_active), .data_tx_done(a_done),
    .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(a_tlast), .frame_len(a_len), .frame_overflow(a_ovf), .frame_count(a_count)
  );

  radar_adc_capture #(.DEPTH(16), .SAMPLE_W(16)) dut_b (
    .aclk(aclk), .areset(areset), .adc_enable(en_b), .adc_valid(adc_valid),
    .adc_data_i(adc_i), .adc_data_q(adc_q), .data_tx_init(init_b),
    .data_tx_ready(b_ready), .data_tx_active(b_active), .data_tx_done(b_done),
    .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(b_tlast), .frame_len(b_len), .frame_overflow(b_ovf), .frame_count(b_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ncyc cycles of adc_enable high, first nval of them with adc_valid; I=c, Q=~c
  task automatic capture(input bit b, input int ncyc, input int nval);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge aclk);
      if (b) en_b = 1'b1; else en_a = 1'b1;
      adc_valid = (c < nval);
      adc_i = 16'(c);
      adc_q = ~16'(c);
    end
    @(negedge aclk);
    en_a = 1'b0; en_b = 1'b0; adc_valid = 1'b0;
    chk("ready_low_in_capture", b ? b_ready : a_ready, 1'b0);
    @(negedge aclk);
    chk("ready_after_fall", b ? b_ready : a_ready, (nval > 0));
  endtask

  // mode 0: tready always 1; mode 1: tready pattern 1,0,0,1
  task automatic stream(input bit b, input int nsamp, input int mode, input int hdr_cnt);
    int exp_total = nsamp + HDR;
    int first = -1, beats = 0, errs = 0, nlast = 0, lastpos = -1;
    int stall_err = 0, dones = 0, done_c = 0, k;
    logic act_first = 1'b0, prev_stall = 1'b0, pl = 1'b0;
    logic [31:0] pd = '0, e;
    sel_b = b;
    if (b) init_b = 1'b1; else init_a = 1'b1;
    for (int c = 1; c <= 4 * exp_total + 40; c++) begin
      @(negedge aclk);
      if (c == 1) begin init_a = 1'b0; init_b = 1'b0; end
      if (prev_stall && !(o_tvalid && o_tdata === pd && o_tlast === pl)) stall_err++;
      if (o_done) begin dones++; done_c = c; end
      m_axis_tready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      if (o_tvalid && first < 0) begin first = c; act_first = o_active; end
      if (o_tvalid && m_axis_tready) begin
        if (HDR == 1 && beats == 0) e = {hdr_cnt[15:0], 1'b0, 15'(nsamp)};
        else begin k = beats - HDR; e = {~16'(k), 16'(k)}; end
        if (o_tdata !== e) errs++;
        if (o_tlast) begin nlast++; lastpos = beats; end
        beats++;
      end
      prev_stall = o_tvalid && !m_axis_tready;
      pd = o_tdata;
      pl = o_tlast;
      if (done_c > 0 && c > done_c) break;
    end
    m_axis_tready = 1'b1;
    chk("beat_count", beats, exp_total);
    chk("data_errors", errs, 0);
    chk("tlast_count", nlast, 1);
    chk("tlast_position", lastpos, exp_total - 1);
    chk("stall_stability_errors", stall_err, 0);
    chk("done_pulse_cycles", dones, 1);
    chk("first_valid_within_2", (first > 0) && (first <= 2), 1'b1);
    chk("active_during_stream", act_first, 1'b1);
  endtask

  initial begin
    @(negedge aclk);
    chk("rst_tvalid", a_tvalid, 1'b0);
    chk("rst_tdata", a_tdata, 32'd0);
    chk("rst_tlast", a_tlast, 1'b0);
    chk("rst_ready", a_ready, 1'b0);
    chk("rst_active_done", {a_active, a_done}, 2'b00);
    chk("rst_frame_len", a_len, 9'd0);
    chk("rst_overflow", a_ovf, 1'b0);
    chk("rst_frame_count", a_count, 32'd0);
    areset = 1'b0;
    @(negedge aclk);

    capture(0, 200, 200);
    chk("basic_len", a_len, 9'd200);
    chk("basic_ovf", a_ovf, 1'b0);
    stream(0, 200, 0, 0);
    chk("basic_count", a_count, 32'd1);
    chk("basic_ready_cleared", a_ready, 1'b0);

    capture(1, 20, 20);
    chk("ovf_len", b_len, 5'd16);
    chk("ovf_flag", b_ovf, 1'b1);
    stream(1, 16, 0, 0);
    chk("ovf_count", b_count, 32'd1);

    capture(0, 64, 64);
    chk("bp_len", a_len, 9'd64);
    stream(0, 64, 1, 1);
    chk("bp_count", a_count, 32'd2);

    capture(0, 10, 0);
    repeat (3) @(negedge aclk);
    chk("zero_ready_stays_low", a_ready, 1'b0);
    chk("zero_len", a_len, 9'd0);
    chk("zero_count_unchanged", a_count, 32'd2);

    capture(0, 8, 8);
    en_a = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    en_a = 1'b0;
    @(negedge aclk);
    chk("retrig_len_held", a_len, 9'd8);
    chk("retrig_ready_held", a_ready, 1'b1);
    stream(0, 8, 0, 2);
    chk("retrig_count", a_count, 32'd3);

    capture(0, 32, 32);
    sel_b = 1'b0;
    init_a = 1'b1;
    @(negedge aclk);
    init_a = 1'b0;
    repeat (3) @(negedge aclk);
    chk("mid_stream_valid", a_tvalid, 1'b1);
    areset = 1'b1;
    #1;
    chk("arst_tvalid", a_tvalid, 1'b0);
    chk("arst_active", a_active, 1'b0);
    chk("arst_count", a_count, 32'd0);
    chk("arst_len", a_len, 9'd0);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);

    capture(0, 4, 4);
    stream(0, 4, 0, 0);
    chk("post_rst_count1", a_count, 32'd1);
    capture(0, 8, 8);
    stream(0, 8, 1, 1);
    chk("post_rst_count2", a_count, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/radar_adc_capture.md
Name: radar_adc_capture

Overview:
- Sits directly downstream of the radar pulse controller.
- Captures FMC150 ADC I/Q samples into an on-chip buffer while the controller's adc_enable is high.
- After capture, it answers the controller's transmit handshake (data_tx_ready / data_tx_init / data_tx_active / data_tx_done) and streams the frame out on AXI-Stream toward the Ethernet packetiser.
- Single clock domain; the upstream CDC is owned by the producers of adc_enable and data_tx_init.

Parameters:
- DEPTH, 1024, buffer depth in samples; power of two, 16..16384.
- SAMPLE_W, 16, width of each I and Q sample.
- ADDR_W, $clog2(DEPTH), buffer address width; derived, not overridden.

Ports:
- aclk  in  1  capture/stream clock.
- areset  in  1  asynchronous active-high reset.
- adc_enable  in  1  high while ADC samples are to be saved (level).
- adc_valid  in  1  qualifies adc_data_i/q this cycle.
- adc_data_i  in  SAMPLE_W  I sample.
- adc_data_q  in  SAMPLE_W  Q sample.
- data_tx_init  in  1  single-cycle request to start streaming.
- data_tx_ready  out  1  a complete frame is buffered and not yet sent.
- data_tx_active  out  1  high while streaming.
- data_tx_done  out  1  single-cycle pulse after the last beat is accepted.
- m_axis_tdata  out  2*SAMPLE_W  {Q,I}.
- m_axis_tvalid  out  1  AXI-S valid.
- m_axis_tready  in  1  AXI-S ready.
- m_axis_tlast  out  1  last beat of frame.
- frame_len  out  ADDR_W+1  samples in current/last frame.
- frame_overflow  out  1  sticky: samples dropped because the buffer was full.
- frame_count  out  32  frames completed since reset; wraps at 2^32.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0, including frame_len, frame_count and frame_overflow.
- States: IDLE, CAPTURE, READY, STREAM, FLUSH.
- IDLE:
  - Rising edge of adc_enable (registered previous value) -> CAPTURE.
  - On that transition: wr_ptr=0, frame_len=0, frame_overflow=0.
  - A sample with adc_valid in the same cycle as the rising edge is written.
- CAPTURE:
  - Each cycle with adc_valid=1 and frame_len<DEPTH: write {Q,I} at wr_ptr, then wr_ptr++ and frame_len++.
  - adc_valid=1 with frame_len==DEPTH: sample dropped, frame_overflow<=1.
  - adc_enable low:
    - frame_len>0 -> READY.
    - frame_len==0 -> IDLE; no ready, frame_count unchanged.
- READY:
  - data_tx_ready=1, registered, asserted the cycle after entry.
  - data_tx_init=1 -> STREAM, rd_ptr=0, data_tx_ready<=0.
  - data_tx_init outside READY is ignored.
- STREAM:
  - data_tx_active=1.
  - RAM read latency is 1 cycle. An output register plus a 1-entry skid holds full-throughput streaming when m_axis_tready=1.
  - First tvalid no later than 2 cycles after data_tx_init.
  - tdata/tvalid/tlast stay stable while tvalid=1 and tready=0.
  - tlast=1 exactly on beat frame_len-1.
  - Last handshake -> FLUSH.
- FLUSH (1 cycle):
  - data_tx_done=1, data_tx_active=0, frame_count++.
  - Next state IDLE.
- adc_enable rising while in READY/STREAM/FLUSH: ignored; the buffered frame is never overwritten.
- frame_len is held after CAPTURE until the next capture starts.
- areset mid-STREAM: tvalid drops immediately (async); the frame is lost.

Optional Feature:
- Macro: RADAR_CAPTURE_HEADER_EN.
- Defined:
  - STREAM emits one header beat before the samples: tdata = {frame_count[15:0], 1'b0 & frame_overflow, frame_len zero-extended to 15 bits}.
  - The tlast rule is unchanged.
  - Total beats = frame_len+1.
- Undefined: no header; beats = frame_len.

Decomposition:
- Package radar_capture_pkg:
  - state enum (3 bits: IDLE=0, CAPTURE=1, READY=2, STREAM=3, FLUSH=4).
  - localparam for the header field layout.
  - function for the {Q,I} packing.
- Sub-module radar_sample_ram: simple dual-port RAM, one write and one registered read port, DEPTH x 2*SAMPLE_W, inferred BRAM.

Test Plan:
- Basic frame:
  - Stimulus: adc_enable high 200 cycles, adc_valid always 1, I=n, Q=~n; then data_tx_init pulse with tready=1.
  - Response: data_tx_ready 1 cycle after enable falls; 200 beats, tdata[15:0]=0..199; tlast on beat 199; data_tx_done single pulse; frame_count=1.
- Overflow, DEPTH=16:
  - Stimulus: 20 valid samples.
  - Response: frame_len=16, frame_overflow=1; exactly 16 beats streamed, samples 0..15.
- Backpressure:
  - Stimulus: tready toggling 1,0,0,1 pattern during a 64-sample stream.
  - Response: no duplicated or missing samples; tdata stable while stalled; tlast on beat 63.
- Zero-length:
  - Stimulus: adc_enable high 10 cycles with adc_valid=0.
  - Response: data_tx_ready never asserts; return to IDLE; frame_count unchanged.
- Re-trigger and reset:
  - Stimulus: adc_enable pulse while READY.
  - Response: frame_len and buffer contents unchanged; the frame then streams intact.
  - Stimulus: areset asserted mid-STREAM.
  - Response: all outputs 0 in the same cycle; IDLE after release.
- Header, with RADAR_CAPTURE_HEADER_EN:
  - Stimulus: 8-sample frame, second frame after reset.
  - Response: first beat = {16'd1, 1'b0, 15'd8}; 9 beats total; tlast on beat 8.
